mem_port_ctrl: RTL
==================

Name: mem_port_ctrl

Overview:
- Parametrised memory-stage bus controller.
- Replaces the single-outstanding CPUEn/CPUValid load handshake with a pipelined port:
  - up to MAX_OUTST loads in flight, in-order responses;
  - byte-enabled stores;
  - explicit pipeline stall output.
- Sits between the X/M pipeline register and the CPU-side memory bus; responses feed the M/W register.

Parameters:
- DATA_W, 32, data bus width (multiple of 8).
- ADDR_W, 32, address width.
- MAX_OUTST, 2, max loads in flight (power of 2, >=1).
- TAG_W, 5, destination-register tag width.
- TIMEOUT_CYC, 255, bus-response timeout in cycles (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  M-stage has a memory op this cycle
- req_wr  in  1  1=store, 0=load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data
- req_be  in  DATA_W/8  byte enables
- req_tag  in  TAG_W  load destination register
- stall  out  1  hold X/M and upstream this cycle
- bus_en  out  1  read request strobe
- bus_wr_en  out  1  write strobe
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_be  out  DATA_W/8  bus byte enables
- bus_valid  in  1  read data returned (in order)
- bus_rdata  in  DATA_W  read data
- rsp_valid  out  1  load response to M/W register
- rsp_data  out  DATA_W  load data
- rsp_tag  out  TAG_W  load destination register
- outst_cnt  out  $clog2(MAX_OUTST)+1  loads in flight
- err  out  1  sticky timeout error (0 unless MEM_TIMEOUT_EN)

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high. Every flop clears on the rising edge of clk while rst=1.
- Reset values:
  - stall, bus_en, bus_wr_en, rsp_valid, err all 0;
  - bus_addr, bus_wdata, bus_be, rsp_data, rsp_tag all 0;
  - outst_cnt 0; tag FIFO empty.
- Bus outputs are registered: accepted request at edge N is driven on the bus in cycle N+1.
- Acceptance (combinational):
  - Load accepted iff req_valid & !req_wr & (outst_cnt<MAX_OUTST).
  - Store accepted iff req_valid & req_wr & (outst_cnt==0). This is the ordering rule: no store passes a pending load.
  - stall = req_valid & !accept.
- Load accept:
  - next cycle bus_en=1 for exactly one cycle, with bus_addr and bus_be driven;
  - req_tag is pushed into the tag FIFO (depth MAX_OUTST).
- Store accept: next cycle bus_wr_en=1 for exactly one cycle, with bus_addr, bus_wdata and bus_be driven. Stores are posted; no response.
- Response:
  - bus_valid pops the FIFO head.
  - Next cycle: rsp_valid=1, rsp_data=bus_rdata, rsp_tag=popped tag, for one cycle.
  - Load-to-response latency = bus latency + 2.
- outst_cnt:
  - +1 on load accept, -1 on bus_valid, unchanged when both happen in the same cycle.
  - A simultaneous pop+push when full is legal; that load is accepted.
- bus_valid with the FIFO empty: ignored, no rsp_valid.
- Unused bus outputs hold their last value. Strobes are 0 when idle.
- Reset mid-transaction: FIFO flushed, outst_cnt=0. Any later bus_valid for a dropped load is ignored.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - a counter runs while outst_cnt>0 and clears on each bus_valid;
  - when it reaches TIMEOUT_CYC, err is set (sticky until rst), the FIFO head is popped, and rsp_valid is emitted with rsp_data=0;
  - this prevents a permanent stall.
- Undefined: no counter; err tied 0; a missing response stalls indefinitely.

Decomposition:
- Package mem_port_pkg holds:
  - mem_op_e (LOAD, STORE);
  - MAX_OUTST_DEF and TIMEOUT_DEF constants;
  - req_t and rsp_t packed structs.
- One sub-module, tag_fifo: synchronous FIFO with push/pop/full/empty/count, parametrised on depth and width, reused for the tag queue.

Test Plan:
- Single load, addr 0x100, tag 3; bus_valid 2 cycles after bus_en with data 0xDEADBEEF -> bus_en one cycle; rsp_valid with rsp_data=0xDEADBEEF, rsp_tag=3; stall never asserted.
- Three back-to-back loads, MAX_OUTST=2, tags 1,2,3, no bus_valid -> first two accepted; stall=1 on the third until the first bus_valid, then accepted; responses in order 1,2,3.
- Store while one load outstanding (req_wr=1, addr 0x40, be 0b0011) -> stall=1 until the load response; then bus_wr_en one cycle with bus_be=0b0011.
- Full FIFO plus simultaneous bus_valid and new load -> load accepted that cycle, outst_cnt stays 2.
- rst pulsed with 2 loads outstanding, then bus_valid -> outst_cnt=0, no rsp_valid.
- MEM_TIMEOUT_EN, TIMEOUT_CYC=8, load with no response -> after 8 cycles err=1, rsp_valid with rsp_data=0, outst_cnt=0.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared types and defaults for the pipelined memory-stage port controller.
// The optional response timeout is enabled with the MEM_TIMEOUT_EN macro (see mem_port_ctrl).
package mem_port_pkg;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } mem_op_e;

    localparam int MAX_OUTST_DEF = 2;
    localparam int TIMEOUT_DEF   = 255;
    localparam int DATA_W_DEF    = 32;
    localparam int ADDR_W_DEF    = 32;
    localparam int TAG_W_DEF     = 5;

    typedef struct packed {
        mem_op_e                     op;
        logic [ADDR_W_DEF-1:0]       addr;
        logic [DATA_W_DEF-1:0]       wdata;
        logic [DATA_W_DEF/8-1:0]     be;
        logic [TAG_W_DEF-1:0]        tag;
    } req_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0]       data;
        logic [TAG_W_DEF-1:0]        tag;
    } rsp_t;

endpackage

// File: rtl/tag_fifo.sv
// Small synchronous FIFO holding destination tags of loads in flight.
// A push into a full FIFO is taken when a pop happens in the same cycle.
module tag_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign empty     = (cnt_q == CNT_W'(0));
    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign count     = cnt_q;
    assign rdata     = mem_q[rd_ptr_q];
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO state register with synchronous flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// Pipelined memory-stage port: up to MAX_OUTST in-order loads, posted byte-enabled stores.
// Define MEM_TIMEOUT_EN to add a bus-response timeout that retires a hung load and sets err.
module mem_port_ctrl
    import mem_port_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MAX_OUTST   = MAX_OUTST_DEF,
    parameter int TAG_W       = 5,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    input  logic                         req_wr,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    input  logic [DATA_W/8-1:0]          req_be,
    input  logic [TAG_W-1:0]             req_tag,
    output logic                         stall,
    output logic                         bus_en,
    output logic                         bus_wr_en,
    output logic [ADDR_W-1:0]            bus_addr,
    output logic [DATA_W-1:0]            bus_wdata,
    output logic [DATA_W/8-1:0]          bus_be,
    input  logic                         bus_valid,
    input  logic [DATA_W-1:0]            bus_rdata,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_data,
    output logic [TAG_W-1:0]             rsp_tag,
    output logic [$clog2(MAX_OUTST):0]   outst_cnt,
    output logic                         err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;

    if (MAX_OUTST < 1 || TIMEOUT_CYC < 1 || (DATA_W % 8) != 0) begin : g_bad_param
        $error("mem_port_ctrl: illegal parameter combination");
    end

    mem_op_e           op_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CNT_W-1:0]  fifo_cnt_s;
    logic [TAG_W-1:0]  head_tag_s;
    logic              bus_pop_s;
    logic              tmo_pop_s;
    logic              pop_s;
    logic              load_acc_s;
    logic              store_acc_s;

    logic              bus_en_q,    bus_en_d;
    logic              bus_wr_en_q, bus_wr_en_d;
    logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [BE_W-1:0]   bus_be_q,    bus_be_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
    logic [TAG_W-1:0]  rsp_tag_q,   rsp_tag_d;
    logic              err_q,       err_d;

    assign op_s      = req_wr ? STORE : LOAD;
    assign bus_pop_s = bus_valid & ~fifo_empty_s;
    assign pop_s     = bus_pop_s | tmo_pop_s;

    // A full queue still takes a load when its head retires in the same cycle;
    // stores wait for an empty queue so they never overtake a pending load.
    assign load_acc_s  = req_valid & (op_s == LOAD) & (~fifo_full_s | pop_s);
    assign store_acc_s = req_valid & (op_s == STORE) & fifo_empty_s;
    assign stall       = req_valid & ~(load_acc_s | store_acc_s);

    tag_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (load_acc_s),
        .pop   (pop_s),
        .wdata (req_tag),
        .rdata (head_tag_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_cnt_s)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Timeout counter: runs while loads are pending, restarts on any bus response.
    always_comb begin
        to_cnt_d  = to_cnt_q;
        tmo_pop_s = 1'b0;
        if (fifo_empty_s || bus_valid) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            tmo_pop_s = 1'b1;
            to_cnt_d  = '0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign tmo_pop_s = 1'b0;
`endif

    // Next values of the registered bus and response outputs.
    always_comb begin
        bus_en_d    = load_acc_s;
        bus_wr_en_d = store_acc_s;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        rsp_valid_d = pop_s;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        err_d       = err_q | tmo_pop_s;
        if (load_acc_s || store_acc_s) begin
            bus_addr_d = req_addr;
            bus_be_d   = req_be;
        end else begin
            bus_addr_d = bus_addr_q;
        end
        if (store_acc_s) begin
            bus_wdata_d = req_wdata;
        end else begin
            bus_wdata_d = bus_wdata_q;
        end
        if (bus_pop_s) begin
            rsp_data_d = bus_rdata;
            rsp_tag_d  = head_tag_s;
        end else if (tmo_pop_s) begin
            rsp_data_d = '0;
            rsp_tag_d  = head_tag_s;
        end else begin
            rsp_data_d = rsp_data_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_en_q    <= 1'b0;
            bus_wr_en_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            bus_en_q    <= bus_en_d;
            bus_wr_en_q <= bus_wr_en_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            err_q       <= err_d;
        end
    end

    assign bus_en    = bus_en_q;
    assign bus_wr_en = bus_wr_en_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = rsp_tag_q;
    assign outst_cnt = fifo_cnt_s;
    assign err       = err_q;

endmodule
